// File: rtl/simon_seq_mem.sv
// simon_seq_mem: register-based Simon-Says colour sequence RAM with registered read data.
// Optional SIMON_MEM_WRITE_THROUGH_EN makes write cycles also drive out_num with in_num.
module simon_seq_mem #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              rw,
  input  logic [DATA_W-1:0] in_num,
  output logic [DATA_W-1:0] out_num
);
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];
  logic [DATA_W-1:0] mem [DEPTH];
  logic in_range;
  assign in_range = {1'b0, address} < DEPTH_L;
  // An X on rw falls through to the read branch.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      out_num <= '0;
    end else if (rw) begin
      if (in_range) mem[address] <= in_num;
`ifdef SIMON_MEM_WRITE_THROUGH_EN
      out_num <= in_num;
`endif
    end else begin
      out_num <= in_range ? mem[address] : '0;
    end
endmodule

// File: tb/tb_simon_seq_mem.sv
// tb_simon_seq_mem: directed plan plus random reads/writes against an array reference model.
module tb_simon_seq_mem;
  logic       clock = 0;
  logic       reset_n = 1;
  logic [3:0] address = 0;
  logic       rw = 0;
  logic [1:0] in_num = 0;
  logic [1:0] out_num;
  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] ref_mem [16];
  logic [1:0] ref_out = 0;

  simon_seq_mem dut (
    .clock(clock), .reset_n(reset_n), .address(address),
    .rw(rw), .in_num(in_num), .out_num(out_num)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_ref();
    for (int i = 0; i < 16; i++) ref_mem[i] = 0;
    ref_out = 0;
  endtask

  task automatic op(input string tag, input logic w, input logic [3:0] a, input logic [1:0] d);
    @(negedge clock);
    rw = w;
    address = a;
    in_num = d;
    @(posedge clock);
    #1;
    if (w) begin
      ref_mem[a] = d;
`ifdef SIMON_MEM_WRITE_THROUGH_EN
      ref_out = d;
`endif
    end else begin
      ref_out = ref_mem[a];
    end
    check(tag, out_num, ref_out);
  endtask

  task automatic async_reset();
    @(negedge clock);
    #2 reset_n = 0;
    #1;
    clear_ref();
    check("async_reset", out_num, 2'd0);
    @(negedge clock);
    reset_n = 1;
  endtask

  initial begin
    clear_ref();
    async_reset();
    for (int a = 0; a < 16; a++) op("reset_read", 0, 4'(a), 0);
    for (int a = 0; a < 10; a++) op("fill_write", 1, 4'(a), 2'(a));
    for (int a = 0; a < 10; a++) begin
      op("fill_read", 0, 4'(a), 0);
      check("fill_pattern", out_num, 2'(a));
    end
    for (int a = 10; a < 16; a++) op("untouched", 0, 4'(a), 0);
    op("wr15", 1, 15, 3);
    op("rd15", 0, 15, 0);
    check("rd15_val", out_num, 2'd3);
    for (int a = 0; a < 15; a++) op("after_wr15", 0, 4'(a), 0);
    op("rd2", 0, 2, 0);
    op("wr5_hold", 1, 5, 3);
`ifdef SIMON_MEM_WRITE_THROUGH_EN
    check("wr5_through", out_num, 2'd3);
    op("wr7_through", 1, 7, 2);
    check("wr7_val", out_num, 2'd2);
    op("rd7", 0, 7, 0);
    check("rd7_val", out_num, 2'd2);
`else
    check("wr5_hold_val", out_num, 2'd2);
`endif
    op("rd5", 0, 5, 0);
    check("rd5_val", out_num, 2'd3);
    op("raw_wr", 1, 9, 2);
    op("raw_rd", 0, 9, 0);
    for (int k = 0; k < 400; k++)
      op("random", 1'($urandom_range(0, 1)), 4'($urandom), 2'($urandom));
    async_reset();
    for (int a = 0; a < 10; a++) op("post_reset", 0, 4'(a), 0);
    for (int k = 0; k < 200; k++)
      op("random2", 1'($urandom_range(0, 1)), 4'($urandom), 2'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/simon_seq_mem.md
Name: simon_seq_mem

Overview:
- Small synchronous single-port RAM holding the Simon-Says colour sequence (2-bit colour code per step).
- The game controller writes a new step with rw=1 and reads steps back for playback/compare with rw=0.
- One shared address bus; registered read data.

Parameters:
- ADDR_W, 4, address width in bits.
- DEPTH, 16, number of entries; must be at most 2**ADDR_W.
- DATA_W, 2, entry width (colour code).

Ports:
- clock  input  1  system clock; all sequential logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  ADDR_W  entry index for the read or write.
- rw  input  1  1 = write in_num to address; 0 = read address.
- in_num  input  DATA_W  write data.
- out_num  output  DATA_W  registered read data.

Behaviour:
- Storage is DEPTH x DATA_W, implemented as registers (not an inferred RAM), so reset can clear it.
- Reset (reset_n=0, asynchronous, takes effect without a clock edge):
  - every entry is cleared to 0;
  - out_num is cleared to 0.
- Reset release is sampled at the next rising edge. The first operation executes on the first rising edge with reset_n=1.
- Write (rw=1 at rising edge):
  - mem[address] <= in_num, visible to any read on a later edge;
  - out_num holds its previous value (feature disabled).
- Read (rw=0 at rising edge):
  - out_num <= mem[address];
  - latency is 1 cycle: address presented before edge N gives data valid after edge N;
  - out_num holds until the next read edge.
- There are no wait states. One operation per cycle. Back-to-back reads at different addresses each return data one cycle later.
- Read immediately after write to the same address (consecutive edges) returns the new data.
- Address range:
  - address >= DEPTH on a write: the write is ignored;
  - address >= DEPTH on a read: out_num <= 0;
  - with the defaults, every address is in range.
- X/Z on rw: treated as a read in simulation. No other side effects.
- Reset asserted mid-operation overrides any write or read in that cycle. All contents are lost.
- No wrap logic inside the block. The controller owns the step counter.

Optional Feature:
- Macro: SIMON_MEM_WRITE_THROUGH_EN.
- Defined: on a write edge, out_num <= in_num as well as updating mem[address], so the written colour shows on out_num the next cycle. An out-of-range write still drives out_num <= in_num but does not store it.
- Not defined: out_num holds on write cycles, as described in Behaviour.

Test Plan:
- Reset: pulse reset_n low, then read addresses 0..15 -> out_num = 0 for every address, each one cycle after its address edge.
- Fill: write addresses 0..9 with in_num = address[1:0], then read 0..9 -> out_num sequence 0,1,2,3,0,1,2,3,0,1.
- Untouched entries: after the fill, read addresses 10..15 -> out_num = 0. Then write address 15 = 3 and read it -> 3, with no other entry changed.
- Hold on write (macro off): read address 2 (out_num=2), then write address 5 = 3 -> out_num stays 2. Then read address 5 -> 3.
- Asynchronous reset mid-sequence: after the fill, drop reset_n between edges -> out_num goes to 0 immediately. After release, read addresses 0..9 -> all 0.
- Write-through (macro on): write address 7 = 2 -> out_num = 2 after that edge. Then read address 7 -> 2.
